// File: rtl/can_bit_destuffer.sv
// CAN / CAN-FD bit destuffer: strips dynamic and fixed stuff bits from the sampled
// bit stream, flags stuff-rule violations and counts dynamic stuff bits modulo 8.
module can_bit_destuffer #(
    parameter int STUFF_LEN = 5,
    parameter int FIXED_LEN = 4,
    parameter int CNT_W     = $clog2(16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sp,
    input  logic       rx,
    input  logic       restart,
    input  logic       stuff_en,
    input  logic       fixed_mode,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic       err_flag,
    output logic [2:0] stuff_cnt
);

    localparam logic [CNT_W-1:0] STUFF_LEN_C = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] FIXED_LEN_C = CNT_W'(FIXED_LEN);

    typedef enum logic {ST_RUN, ST_ERROR} state_t;

    state_t           state_q;
    logic             last_bit_q;
    logic             pending_q;
    logic             fixed_prev_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] fixed_cnt_q;
    logic [CNT_W-1:0] run_d;
    logic             bit_valid_q;
    logic             bit_out_q;
    logic             stuff_bit_q;
    logic             stuff_err_q;
    logic             err_flag_q;
    logic [2:0]       stuff_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Run length after accepting rx as a data bit.
    always_comb begin
        run_d = 1;
        if (rx == last_bit_q)
            run_d = sat_inc(run_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            last_bit_q   <= 1'b1;
            pending_q    <= 1'b0;
            fixed_prev_q <= 1'b0;
            run_q        <= '0;
            fixed_cnt_q  <= '0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            stuff_bit_q  <= 1'b0;
            stuff_err_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            stuff_cnt_q  <= '0;
        end else begin
            bit_valid_q <= 1'b0;
            stuff_bit_q <= 1'b0;
            stuff_err_q <= 1'b0;
            if (restart) begin
                state_q      <= ST_RUN;
                last_bit_q   <= 1'b1;
                pending_q    <= 1'b0;
                fixed_prev_q <= 1'b0;
                run_q        <= '0;
                fixed_cnt_q  <= '0;
                err_flag_q   <= 1'b0;
                stuff_cnt_q  <= '0;
            end else if (sp && state_q == ST_RUN) begin
                if (!stuff_en) begin
                    bit_valid_q  <= 1'b1;
                    bit_out_q    <= rx;
                    last_bit_q   <= rx;
                    run_q        <= '0;
                    pending_q    <= 1'b0;
                    fixed_cnt_q  <= '0;
                    fixed_prev_q <= 1'b0;
                end else if (fixed_mode) begin
                    // First bit after entering fixed mode, or every FIXED_LEN+1th, is a stuff bit.
                    fixed_prev_q <= 1'b1;
                    run_q        <= '0;
                    pending_q    <= 1'b0;
                    if (!fixed_prev_q || fixed_cnt_q >= FIXED_LEN_C) begin
                        if (rx == last_bit_q) begin
                            stuff_err_q <= 1'b1;
                            err_flag_q  <= 1'b1;
                            state_q     <= ST_ERROR;
                        end else begin
                            stuff_bit_q <= 1'b1;
                            last_bit_q  <= rx;
                            fixed_cnt_q <= '0;
                        end
                    end else begin
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= rx;
                        last_bit_q  <= rx;
                        fixed_cnt_q <= sat_inc(fixed_cnt_q);
                    end
                end else begin
                    fixed_prev_q <= 1'b0;
                    fixed_cnt_q  <= '0;
                    if (pending_q) begin
                        if (rx == last_bit_q) begin
                            stuff_err_q <= 1'b1;
                            err_flag_q  <= 1'b1;
                            state_q     <= ST_ERROR;
                        end else begin
                            // The stuff bit opens the next run.
                            stuff_bit_q <= 1'b1;
                            stuff_cnt_q <= stuff_cnt_q + 3'd1;
                            run_q       <= CNT_W'(1);
                            last_bit_q  <= rx;
                            pending_q   <= 1'b0;
                        end
                    end else begin
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= rx;
                        last_bit_q  <= rx;
                        run_q       <= run_d;
                        pending_q   <= (run_d == STUFF_LEN_C);
                    end
                end
            end
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign stuff_bit = stuff_bit_q;
    assign stuff_err = stuff_err_q;
    assign err_flag  = err_flag_q;
    assign stuff_cnt = stuff_cnt_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed-vector bench for can_bit_destuffer (STUFF_LEN=5, FIXED_LEN=4).
module tb_can_bit_destuffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sp;
    logic       rx;
    logic       restart;
    logic       stuff_en;
    logic       fixed_mode;
    logic       bit_valid;
    logic       bit_out;
    logic       stuff_bit;
    logic       stuff_err;
    logic       err_flag;
    logic [2:0] stuff_cnt;

    int n_vec = 0;
    int n_err = 0;

    can_bit_destuffer #(.STUFF_LEN(5), .FIXED_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sp         (sp),
        .rx         (rx),
        .restart    (restart),
        .stuff_en   (stuff_en),
        .fixed_mode (fixed_mode),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .stuff_bit  (stuff_bit),
        .stuff_err  (stuff_err),
        .err_flag   (err_flag),
        .stuff_cnt  (stuff_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One sample point, then one idle cycle; checks the response and that pulses end.
    task automatic bit_tx(input string tag, input logic b, input logic ev,
                          input logic es, input logic ee);
        rx = b;
        sp = 1'b1;
        @(posedge clk); #1;
        sp = 1'b0;
        chk({tag, ".valid"}, 8'(bit_valid), 8'(ev));
        chk({tag, ".stuff"}, 8'(stuff_bit), 8'(es));
        chk({tag, ".err"},   8'(stuff_err), 8'(ee));
        if (ev) chk({tag, ".out"}, 8'(bit_out), 8'(b));
        @(posedge clk); #1;
        chk({tag, ".idle"}, {5'd0, bit_valid, stuff_bit, stuff_err}, 8'd0);
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk({tag, ".flag"}, 8'(err_flag), 8'd0);
        chk({tag, ".cnt"},  8'(stuff_cnt), 8'd0);
    endtask

    logic v;

    initial begin
        reset = 1'b0; sp = 1'b1; rx = 1'b1; restart = 1'b0;
        stuff_en = 1'b1; fixed_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst.outs", {2'd0, bit_valid, bit_out, stuff_bit, stuff_err, err_flag, 1'b0}, 8'd0);
            chk("rst.cnt", 8'(stuff_cnt), 8'd0);
        end
        sp = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Five recessive bits after reset, then the required dominant stuff bit.
        for (int i = 0; i < 5; i++) bit_tx("rst.run", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("rst.stuff", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.stuffcnt", 8'(stuff_cnt), 8'd1);

        // 00000 1 1111 0 1 : stuff bits at positions 6 and 11.
        do_restart("rs1");
        for (int i = 0; i < 5; i++) bit_tx("dyn.a", 1'b0, 1'b1, 1'b0, 1'b0);
        bit_tx("dyn.s1", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) bit_tx("dyn.b", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("dyn.s2", 1'b0, 1'b0, 1'b1, 1'b0);
        bit_tx("dyn.c", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("dyn.cnt", 8'(stuff_cnt), 8'd2);
        chk("dyn.flag", 8'(err_flag), 8'd0);

        // Six equal bits: stuff error, then ERROR state swallows sample points.
        do_restart("rs2");
        for (int i = 0; i < 5; i++) bit_tx("err.a", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("err.bad", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("err.flag", 8'(err_flag), 8'd1);
        bit_tx("err.ignored", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err.sticky", 8'(err_flag), 8'd1);
        do_restart("rs3");
        chk("rs3.keepout", 8'(bit_out), 8'd1);

        // Fixed mode entry after a dominant data bit, good stuff bits.
        bit_tx("fx.d1", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fx.d0", 1'b0, 1'b1, 1'b0, 1'b0);
        fixed_mode = 1'b1;
        bit_tx("fx.s1", 1'b1, 1'b0, 1'b1, 1'b0);
        bit_tx("fx.a", 1'b0, 1'b1, 1'b0, 1'b0);
        bit_tx("fx.b", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fx.c", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fx.d", 1'b0, 1'b1, 1'b0, 1'b0);
        bit_tx("fx.s2", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fx.cnt", 8'(stuff_cnt), 8'd0);
        fixed_mode = 1'b0;

        // Same frame with a bad second fixed stuff bit.
        do_restart("rs4");
        bit_tx("fe.d1", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fe.d0", 1'b0, 1'b1, 1'b0, 1'b0);
        fixed_mode = 1'b1;
        bit_tx("fe.s1", 1'b1, 1'b0, 1'b1, 1'b0);
        bit_tx("fe.a", 1'b0, 1'b1, 1'b0, 1'b0);
        bit_tx("fe.b", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fe.c", 1'b1, 1'b1, 1'b0, 1'b0);
        bit_tx("fe.d", 1'b0, 1'b1, 1'b0, 1'b0);
        bit_tx("fe.bad", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fe.flag", 8'(err_flag), 8'd1);
        fixed_mode = 1'b0;

        // Pass-through: ten equal bits, no stuffing.
        do_restart("rs5");
        stuff_en = 1'b0;
        for (int i = 0; i < 10; i++) bit_tx("pt", 1'b0, 1'b1, 1'b0, 1'b0);
        stuff_en = 1'b1;

        // restart wins over a coincident sample point.
        restart = 1'b1; sp = 1'b1; rx = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; sp = 1'b0;
        chk("rsp.valid", 8'(bit_valid), 8'd0);
        chk("rsp.stuff", 8'(stuff_bit), 8'd0);

        // Nine dynamic stuff bits: counter wraps to 1.
        do_restart("rs6");
        v = 1'b0;
        for (int i = 0; i < 5; i++) bit_tx("w9.a", v, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            v = ~v;
            bit_tx("w9.s", v, 1'b0, 1'b1, 1'b0);
            if (k < 9)
                for (int i = 0; i < 4; i++) bit_tx("w9.d", v, 1'b1, 1'b0, 1'b0);
        end
        chk("w9.cnt", 8'(stuff_cnt), 8'd1);

        // Reset while a stuff bit is pending: next bit is plain data.
        do_restart("rs7");
        for (int i = 0; i < 5; i++) bit_tx("mr.a", 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("mr.out", 8'(bit_out), 8'd0);
        bit_tx("mr.next", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mr.flag", 8'(err_flag), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
